mdu_sequencer: RTL

//  Multi-cycle unsigned multiply/divide unit (MULTU/DIVU) built on the shared ALU206 instance.

---
 rtl/mdu_sequencer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
//   Multi-cycle unsigned multiply / divide unit (MULTU / DIVU). It does not
//   own an adder. It borrows the shared ALU for 32 iterations and performs one
//   add (multiply) or one subtract (divide) per cycle. The final {hi, lo}
//   pair is valid from the cycle in which done pulses.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request pulse, sampled only while busy is low
//   op           in   0 = MULTU, 1 = DIVU (sampled with start)
//   opa          in   multiplicand / dividend (sampled with start)
//   opb          in   multiplier / divisor (sampled with start)
//   busy         out  high in INIT and RUN; the ALU port belongs to this block
//   done         out  one-cycle pulse, hi/lo valid from this cycle
//   hi           out  MULTU: product[63:32]   DIVU: remainder
//   lo           out  MULTU: product[31:0]    DIVU: quotient
//   div_by_zero  out  set with done for DIVU by 0, cleared on next accepted start
//   alu_ctr      out  ALU operation select
//   alu_a        out  ALU operand A
//   alu_b        out  ALU operand B
//   alu_shamt    out  ALU shift amount, tied to 0
//   alu_result   in   combinational ALU result
module mdu_sequencer #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [4:0]  ALU_ADDU = 5'd1,
  parameter logic [4:0]  ALU_SUBU = 5'd3,
  parameter logic [4:0]  ALU_IDLE = 5'd31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [4:0]       alu_ctr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [4:0] LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [4:0]       cnt;
  logic             op_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] div_sh;

  // One shift-add multiply step. The ALU result is hi + (lo[0] ? mcand : 0).
  // It wraps mod 2^WIDTH, so the lost carry shows up as the result being
  // smaller than hi. The carry then becomes the new MSB of the shifted hi
  // word. The bit shifted out of hi enters lo from the top.
  function automatic logic [2*WIDTH-1:0] mul_step(
    input logic [WIDTH-1:0] hi_v,
    input logic [WIDTH-1:0] lo_v,
    input logic [WIDTH-1:0] sum
  );
    logic carry;
    carry = (sum < hi_v);
    return {carry, sum[WIDTH-1:1], sum[0], lo_v[WIDTH-1:1]};
  endfunction

  // One restoring-divide step on the partial remainder shifted left by one.
  // If hi[MSB] was set before the shift, the shifted value really has WIDTH+1
  // bits and always exceeds the divisor. The wrapped ALU difference is then
  // still the correct remainder, because the true difference is below 2^WIDTH.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] hi_v,
    input logic [WIDTH-1:0] lo_v,
    input logic [WIDTH-1:0] dvsr,
    input logic [WIDTH-1:0] diff
  );
    logic [WIDTH-1:0] sh;
    logic             ge;
    sh = {hi_v[WIDTH-2:0], lo_v[WIDTH-1]};
    ge = hi_v[WIDTH-1] | (sh >= dvsr);
    if (ge) begin
      return {diff, lo_v[WIDTH-2:0], 1'b1};
    end else begin
      return {sh, lo_v[WIDTH-2:0], 1'b0};
    end
  endfunction

  assign div_sh    = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign alu_shamt = 5'd0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, status outputs and ALU port drive
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    alu_ctr   = ALU_IDLE;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        busy = 1'b1;
        // A zero divisor skips the iterations entirely.
        if (op_q && (opb_q == '0)) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (op_q) begin
          alu_ctr = ALU_SUBU;
          alu_a   = div_sh;
          alu_b   = opb_q;
        end else begin
          alu_ctr = ALU_ADDU;
          alu_a   = hi;
          alu_b   = lo[0] ? opa_q : '0;
        end
        if (cnt == LAST_ITER) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        // A start request in the done cycle is accepted, so operations can
        // run back to back.
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_INIT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, iteration counter and HI/LO working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      cnt         <= 5'd0;
    end else begin
      if (accept) begin
        op_q        <= op;
        opa_q       <= opa;
        opb_q       <= opb;
        div_by_zero <= 1'b0;
      end
      case (state)
        S_INIT: begin
          cnt <= 5'd0;
          if (!op_q) begin
            // The multiplier sits in lo and is consumed LSB first as the
            // product shifts in from the top.
            hi <= '0;
            lo <= opb_q;
          end else if (opb_q == '0) begin
            hi          <= opa_q;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            // The dividend sits in lo. It is shifted into hi MSB first, and
            // quotient bits fill lo from the bottom.
            hi <= '0;
            lo <= opa_q;
          end
        end
        S_RUN: begin
          cnt <= cnt + 5'd1;
          if (op_q) begin
            {hi, lo} <= div_step(hi, lo, opb_q, alu_result);
          end else begin
            {hi, lo} <= mul_step(hi, lo, alu_result);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
